// File: rtl/mux_arbitrado.sv
// Arbitrated N:1 mux: fixed select or round-robin over valid/ready input channels.
// Latency: 1 cycle from acceptance to valido_saida, full throughput.
// Backpressure: held output stalls all inputs (pronto_entrada=0) until pronto_saida.
module mux_arbitrado #(
    parameter int LARGURA      = 16,
    parameter int NUM_ENTRADAS = 4,
    parameter int SEL_W        = $clog2(NUM_ENTRADAS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_ENTRADAS*LARGURA-1:0] entrada,
    input  logic [NUM_ENTRADAS-1:0]         valido_entrada,
    output logic [NUM_ENTRADAS-1:0]         pronto_entrada,
    input  logic [SEL_W-1:0]                controle,
    input  logic                            modo,
    output logic [LARGURA-1:0]              saida,
    output logic                            valido_saida,
    input  logic                            pronto_saida
);

    localparam int              NPAD  = 1 << SEL_W;
    localparam logic [SEL_W:0]  N_EXT = (SEL_W+1)'(NUM_ENTRADAS);

    logic [SEL_W-1:0]   ponteiro;
    logic [SEL_W-1:0]   indice;
    logic [SEL_W:0]     cand;
    logic               conceder;
    logic               slot_livre;
    logic               transferencia;
    logic [NPAD-1:0]    valido_pad;
    logic [NPAD-1:0]    pronto_pad;
    logic [LARGURA-1:0] dado;

    assign slot_livre = !valido_saida || pronto_saida;

    // Padding to a power of two keeps out-of-range selects harmless.
    always_comb begin
        valido_pad = '0;
        valido_pad[NUM_ENTRADAS-1:0] = valido_entrada;
    end

    always_comb begin
        conceder = 1'b0;
        indice   = '0;
        cand     = '0;
        if (modo) begin
            for (int k = 0; k < NUM_ENTRADAS; k++) begin
                cand = {1'b0, ponteiro} + (SEL_W+1)'(k);
                if (cand >= N_EXT)
                    cand = cand - N_EXT;
                if (!conceder && valido_pad[cand[SEL_W-1:0]]) begin
                    conceder = 1'b1;
                    indice   = cand[SEL_W-1:0];
                end
            end
        end else if (({1'b0, controle} < N_EXT) && valido_pad[controle]) begin
            conceder = 1'b1;
            indice   = controle;
        end
    end

    always_comb begin
        pronto_pad = '0;
        if (reset && conceder && slot_livre)
            pronto_pad[indice] = 1'b1;
    end

    assign pronto_entrada = pronto_pad[NUM_ENTRADAS-1:0];
    assign transferencia  = |(pronto_entrada & valido_entrada);

    always_comb begin
        dado = '0;
        for (int i = 0; i < NUM_ENTRADAS; i++) begin
            if (indice == SEL_W'(i))
                dado = entrada[i*LARGURA +: LARGURA];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            saida        <= '0;
            valido_saida <= 1'b0;
            ponteiro     <= '0;
        end else begin
            if (slot_livre) begin
                valido_saida <= transferencia;
                if (transferencia)
                    saida <= dado;
            end
            // Only round-robin grants advance the pointer.
            if (transferencia && modo)
                ponteiro <= (indice == SEL_W'(NUM_ENTRADAS-1)) ? '0 : indice + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_arbitrado.sv
module tb_mux_arbitrado;

    logic        clock;
    logic        reset;
    logic [63:0] entrada;
    logic [3:0]  valido_entrada;
    logic [3:0]  pronto_entrada;
    logic [1:0]  controle;
    logic        modo;
    logic [15:0] saida;
    logic        valido_saida;
    logic        pronto_saida;

    logic [47:0] entrada3;
    logic [2:0]  valido3;
    logic [2:0]  pronto3;
    logic [1:0]  ctrl3;
    logic        modo3;
    logic [15:0] saida3;
    logic        vld3;
    logic        prs3;

    int checks = 0;
    int errors = 0;

    mux_arbitrado dut (
        .clock(clock), .reset(reset), .entrada(entrada),
        .valido_entrada(valido_entrada), .pronto_entrada(pronto_entrada),
        .controle(controle), .modo(modo), .saida(saida),
        .valido_saida(valido_saida), .pronto_saida(pronto_saida)
    );

    mux_arbitrado #(.LARGURA(16), .NUM_ENTRADAS(3)) dut3 (
        .clock(clock), .reset(reset), .entrada(entrada3),
        .valido_entrada(valido3), .pronto_entrada(pronto3),
        .controle(ctrl3), .modo(modo3), .saida(saida3),
        .valido_saida(vld3), .pronto_saida(prs3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Reference model: grant rules evaluated directly on channel indices.
    int          m_ptr;
    logic [15:0] m_out;
    logic        m_vld;

    function automatic int grant(input int ptr, input logic md, input logic [1:0] c, input logic [3:0] v);
        if (!md) return v[c] ? int'(c) : -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin
        int g;
        if (!reset) begin
            m_ptr <= 0;
            m_out <= '0;
            m_vld <= 1'b0;
        end else if (!m_vld || pronto_saida) begin
            g = grant(m_ptr, modo, controle, valido_entrada);
            if (g >= 0) begin
                m_out <= entrada[g*16 +: 16];
                m_vld <= 1'b1;
                if (modo) m_ptr <= (g + 1) % 4;
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        int g;
        logic [3:0] ep;
        ep = '0;
        g  = grant(m_ptr, modo, controle, valido_entrada);
        if (reset && (!m_vld || pronto_saida) && g >= 0) ep[g] = 1'b1;
        chk("model_saida", 32'(saida), 32'(m_out));
        chk("model_valido", 32'(valido_saida), 32'(m_vld));
        chk("model_pronto", 32'(pronto_entrada), 32'(ep));
    end

    logic [15:0] seq_rr [5];
    logic [3:0]  seq_g  [4];
    logic [15:0] hold;

    initial begin
        seq_rr = '{16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'hA0};
        seq_g  = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
        reset = 1'b0; modo = 1'b0; controle = 2'd0; valido_entrada = 4'h0; pronto_saida = 1'b0;
        entrada = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        entrada3 = {16'hB2, 16'hB1, 16'hB0}; valido3 = 3'b111; ctrl3 = 2'd0; modo3 = 1'b0; prs3 = 1'b1;
        #2;
        chk("rst_saida", 32'(saida), 32'h0);
        chk("rst_valido", 32'(valido_saida), 32'h0);
        chk("rst_pronto", 32'(pronto_entrada), 32'h0);

        // Fixed select on channel 2.
        controle = 2'd2; valido_entrada = 4'hF; pronto_saida = 1'b1;
        #5 reset = 1'b1;
        @(posedge clock);
        repeat (3) begin
            @(negedge clock);
            chk("fix_saida", 32'(saida), 32'hA2);
            chk("fix_pronto", 32'(pronto_entrada), 32'b0100);
        end
        chk("n3_valido", 32'(vld3), 32'h1);
        chk("n3_saida", 32'(saida3), 32'hB0);

        // Round-robin over all four channels, pointer wraps.
        @(posedge clock);
        #1 modo = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("rr_saida", 32'(saida), 32'(seq_rr[i]));
        end

        // Only channels 1 and 3 valid.
        #1 valido_entrada = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1 chk("rr13_pronto", 32'(pronto_entrada), 32'(seq_g[i]));
            @(negedge clock);
            #1;
        end

        // Backpressure for three cycles, then same-cycle refill.
        valido_entrada = 4'hF; pronto_saida = 1'b0; hold = saida; ctrl3 = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("bp_saida", 32'(saida), 32'(hold));
            chk("bp_valido", 32'(valido_saida), 32'h1);
            chk("bp_pronto", 32'(pronto_entrada), 32'h0);
        end
        chk("bp_hold_word", 32'(hold), 32'hA3);
        chk("n3_nogrant_valido", 32'(vld3), 32'h0);
        chk("n3_nogrant_pronto", 32'(pronto3), 32'h0);
        #1 pronto_saida = 1'b1;
        #1 chk("bp_refill_pronto", 32'(pronto_entrada), 32'b0001);
        @(negedge clock);
        chk("bp_refill_saida", 32'(saida), 32'hA0);

        // Asynchronous reset between edges while holding a word.
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("arst_saida", 32'(saida), 32'h0);
        chk("arst_valido", 32'(valido_saida), 32'h0);
        chk("arst_pronto", 32'(pronto_entrada), 32'h0);
        #2 reset = 1'b1;
        #1 chk("arst_restart_pronto", 32'(pronto_entrada), 32'b0001);
        @(negedge clock);
        chk("arst_restart_saida", 32'(saida), 32'hA0);
        repeat (4) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arbitrado.md
MUX_ARBITRADO -- requirements
Module: mux_arbitrado

Interface
REQ-001 The block SHALL take parameter LARGURA, default 16, the data width of each input and of the output.
REQ-002 The block SHALL take parameter NUM_ENTRADAS, default 4, the number of input channels (legal range 2..16).
REQ-003 The block SHALL take derived parameter SEL_W = ceil(log2(NUM_ENTRADAS)), the select width.
REQ-004 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, reset; asynchronous, active-low.
REQ-006 The block SHALL have port entrada, input, NUM_ENTRADAS*LARGURA bits, the packed input data; channel i occupies bits [i*LARGURA +: LARGURA].
REQ-007 The block SHALL have port valido_entrada, input, NUM_ENTRADAS bits, per-channel valid.
REQ-008 The block SHALL have port pronto_entrada, output, NUM_ENTRADAS bits, per-channel accept.
REQ-009 The block SHALL have port controle, input, SEL_W bits, the channel select in fixed mode.
REQ-010 The block SHALL have port modo, input, 1 bit: 0 = fixed select, 1 = round-robin.
REQ-011 The block SHALL have port saida, output, LARGURA bits, the registered output data.
REQ-012 The block SHALL have port valido_saida, output, 1 bit, output valid.
REQ-013 The block SHALL have port pronto_saida, input, 1 bit, downstream ready.

Function
REQ-014 The block SHALL hold one output register (saida, valido_saida), giving 1-cycle latency from acceptance to valido_saida=1.
REQ-015 Output slot free: the slot SHALL be free when valido_saida=0 or pronto_saida=1 (consume and refill in the same cycle, full throughput).
REQ-016 Fixed mode (modo=0): the granted channel SHALL be controle, provided controle < NUM_ENTRADAS and valido_entrada[controle]=1.
REQ-017 Fixed mode: controle >= NUM_ENTRADAS SHALL produce no grant, with all pronto_entrada=0.
REQ-018 Round-robin mode (modo=1): the granted channel SHALL be the first valid channel found searching upward from ponteiro, wrapping from NUM_ENTRADAS-1 to 0.
REQ-019 Round-robin mode: ponteiro SHALL reset to 0 and, after each accepted transfer, load (granted index + 1) mod NUM_ENTRADAS.
REQ-020 Round-robin mode: ponteiro SHALL be unchanged when no transfer occurs; fixed-mode transfers SHALL NOT modify ponteiro.
REQ-021 pronto_entrada[i] SHALL be 1 only for the granted channel i, only while the slot is free; it is combinational, one-hot or zero.
REQ-022 A transfer on channel i SHALL occur when valido_entrada[i] and pronto_entrada[i] are both 1; the next saida equals that channel's data and valido_saida=1.
REQ-023 When the slot is free and no transfer occurs, valido_saida SHALL go 0 next cycle and saida SHALL hold its last value.
REQ-024 When valido_saida=1 and pronto_saida=0, saida and valido_saida SHALL remain stable and all pronto_entrada SHALL be 0.
REQ-025 A change of modo or controle SHALL take effect on the same cycle's grant, and SHALL never alter a held output.
REQ-026 No data SHALL be duplicated or dropped: every accepted word appears on saida exactly once.

Reset
REQ-027 While reset=0, the block SHALL force saida=0, valido_saida=0 and ponteiro=0 immediately, regardless of clock; pronto_entrada SHALL be all 0.
REQ-028 Reset mid-transfer SHALL discard the held word; the first acceptance SHALL occur on the first rising edge with reset=1.

Verification
REQ-029 Fixed mode, controle=2, all channels valid with data 0xA0..0xA3, pronto_saida=1 -> saida=0xA2 every cycle from cycle 1, pronto_entrada=4'b0100.
REQ-030 Round-robin mode, all four valid, pronto_saida=1 -> saida sequence 0xA0,0xA1,0xA2,0xA3,0xA0; ponteiro wraps 3->0.
REQ-031 Round-robin mode, only channels 1 and 3 valid -> grants 1,3,1,3; channels 0 and 2 never granted.
REQ-032 Backpressure: pronto_saida=0 for 3 cycles with valido_saida=1 -> saida stable, pronto_entrada=0; pronto_saida=1 -> same-cycle refill, no word lost.
REQ-033 Fixed mode, NUM_ENTRADAS=3, controle=3 -> no grant, valido_saida=0 after one cycle.
REQ-034 reset=0 asserted between clock edges while valido_saida=1 -> saida=0 and valido_saida=0 immediately; after release, round-robin restarts at channel 0.
